// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register with trap/mret redirect, stall, and circular return-address stack
module fetch_pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int              STEP         = 4,
   parameter int              RAS_DEPTH    = 4,
   localparam int             CW           = $clog2(RAS_DEPTH + 1),
   localparam int             PW           = $clog2(RAS_DEPTH)
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic            Busy,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] Result,
   input  logic            Call,
   input  logic            Ret,
   input  logic            Trap,
   input  logic [XLEN-1:0] Trap_Vector,
   input  logic            Mret,
   input  logic [XLEN-1:0] Epc,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PC_Plus_Step,
   output logic [CW-1:0]   RAS_Count,
   output logic            Ret_Underflow
);
   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_wp;
   logic            r_uf;
   logic [XLEN-1:0] r_ras [RAS_DEPTH];
   logic            w_acc, w_pop, w_push, w_uf;
   logic [PW-1:0]   w_top, w_wp_inc;
   logic [XLEN-1:0] w_pc_nxt;
   assign PC            = r_pc;
   assign RAS_Count     = r_cnt;
   assign Ret_Underflow = r_uf;
   assign PC_Plus_Step  = r_pc + XLEN'(STEP);
   // r_wp is the next free slot; the top entry sits just below it, wrapping circularly
   always_comb begin
      w_acc    = !Reset && !Trap && !Mret && !Busy;
      w_pop    = w_acc && Ret && (r_cnt != '0);
      w_uf     = w_acc && Ret && (r_cnt == '0);
      w_push   = w_acc && Call;
      w_top    = (r_wp == '0) ? PW'(RAS_DEPTH - 1) : r_wp - 1'b1;
      w_wp_inc = (r_wp == PW'(RAS_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      w_pc_nxt = Trap ? Trap_Vector : Mret ? Epc : Busy ? r_pc :
                 w_pop ? r_ras[w_top] : (Ret || PCSrc) ? Result : PC_Plus_Step;
   end
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_pc  <= RESET_VECTOR;
         r_cnt <= '0;
         r_wp  <= '0;
         r_uf  <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         r_uf <= w_uf;
         if (w_pop && !w_push) begin
            r_wp  <= w_top;
            r_cnt <= r_cnt - 1'b1;
         end else if (w_push && !w_pop) begin
            r_wp <= w_wp_inc;
            if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + 1'b1;
         end
      end
   end
   // a simultaneous pop+push rewrites the top in place
   always_ff @(posedge CLK) begin
      if (w_push) r_ras[w_pop ? w_top : r_wp] <= PC_Plus_Step;
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed-vector bench with immediate assertions
module tb_fetch_pc_unit;
   logic        CLK = 1'b0;
   logic        Reset, Busy, PCSrc, Call, Ret, Trap, Mret;
   logic [31:0] Result, Trap_Vector, Epc;
   logic [31:0] PC, PC_Plus_Step;
   logic [2:0]  RAS_Count;
   logic        Ret_Underflow;
   int          n_cmp = 0;
   int          n_err = 0;

   fetch_pc_unit dut (
      .CLK(CLK), .Reset(Reset), .Busy(Busy), .PCSrc(PCSrc), .Result(Result),
      .Call(Call), .Ret(Ret), .Trap(Trap), .Trap_Vector(Trap_Vector),
      .Mret(Mret), .Epc(Epc), .PC(PC), .PC_Plus_Step(PC_Plus_Step),
      .RAS_Count(RAS_Count), .Ret_Underflow(Ret_Underflow)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Reset = 0; Busy = 0; PCSrc = 0; Call = 0; Ret = 0; Trap = 0; Mret = 0;
      Result = 32'h0; Trap_Vector = 32'h0; Epc = 32'h0;
   endtask

   task automatic chk_st(input string tag, input logic [31:0] pc, input logic [31:0] cnt, input logic uf);
      chk({tag, "_pc"}, PC, pc);
      chk({tag, "_cnt"}, 32'(RAS_Count), cnt);
      chk({tag, "_uf"}, 32'(Ret_Underflow), 32'(uf));
   endtask

   initial begin
      logic [31:0] targ [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
      logic [31:0] rets [4] = '{32'h44, 32'h34, 32'h24, 32'h14};
      idle();
      Reset = 1; Busy = 1; PCSrc = 1; Result = 32'h1234; tick();
      chk_st("reset", 32'h0, 0, 0);
      idle();
      tick(); chk("seq1", PC, 32'h4);
      tick(); chk("seq2", PC, 32'h8);
      tick(); chk("seq3", PC, 32'hC);
      chk("pcps", PC_Plus_Step, 32'h10);

      PCSrc = 1; Result = 32'h100; tick(); chk("jmp100", PC, 32'h100);
      Call = 1; Result = 32'h400; tick(); chk_st("call", 32'h400, 1, 0);
      idle(); tick(); chk("after_call", PC, 32'h404);
      Ret = 1; PCSrc = 1; Result = 32'hDEAD_0000; tick(); chk_st("ret", 32'h104, 0, 0);

      idle(); PCSrc = 1; Result = 32'h0; tick(); chk("jmp0", PC, 32'h0);
      for (int i = 0; i < 5; i++) begin
         Call = 1; PCSrc = 1; Result = targ[i]; tick();
         chk_st($sformatf("call%0d", i), targ[i], (i < 4) ? i + 1 : 4, 0);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         Ret = 1; Result = 32'hBAD0; tick();
         chk_st($sformatf("ret%0d", i), rets[i], 3 - i, 0);
      end

      Ret = 1; Result = 32'h80; tick(); chk_st("uf", 32'h80, 0, 1);
      idle(); tick(); chk_st("uf_clr", 32'h84, 0, 0);

      Busy = 1; PCSrc = 1; Call = 1; Ret = 1; Result = 32'h300;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_st($sformatf("busy%0d", i), 32'h84, 0, 0);
      end
      Trap = 1; Mret = 1; Trap_Vector = 32'h200; Epc = 32'h500; tick();
      chk_st("trap", 32'h200, 0, 0);
      Trap = 0; tick(); chk_st("mret", 32'h500, 0, 0);

      idle(); PCSrc = 1; Result = 32'hFFFF_FFFC; tick(); chk("top", PC, 32'hFFFF_FFFC);
      chk("pcps_wrap", PC_Plus_Step, 32'h0);
      idle(); tick(); chk("wrap", PC, 32'h0);

      Call = 1; PCSrc = 1; Result = 32'h40; tick(); chk_st("call40", 32'h40, 1, 0);
      Ret = 1; Result = 32'h999; tick(); chk_st("callret", 32'h4, 1, 0);
      idle(); Ret = 1; tick(); chk_st("ret_repl", 32'h44, 0, 0);
      Call = 1; Ret = 1; Result = 32'h90; tick(); chk_st("callret_empty", 32'h90, 1, 1);
      idle(); Ret = 1; tick(); chk_st("ret_48", 32'h48, 0, 0);

      idle(); Call = 1; tick(); chk_st("call_pre_rst", 32'h4C, 1, 0);
      Busy = 1; Reset = 1; Trap = 1; Trap_Vector = 32'h700; tick();
      chk_st("busy_reset", 32'h0, 0, 0);
      idle(); tick(); chk_st("post_reset", 32'h4, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of PC and all address ports.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4: sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, legal 2..16: return-address-stack entries.
REQ-005 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-006 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port Busy, input, 1: stall; hold PC and RAS.
REQ-008 SHALL have port PCSrc, input, 1: taken branch/jump, target on Result.
REQ-009 SHALL have port Result, input, XLEN: branch/jump target.
REQ-010 SHALL have port Call, input, 1: current jump is a call (push return address).
REQ-011 SHALL have port Ret, input, 1: current jump is a return (pop RAS).
REQ-012 SHALL have port Trap, input, 1: exception/interrupt redirect.
REQ-013 SHALL have port Trap_Vector, input, XLEN: trap target.
REQ-014 SHALL have port Mret, input, 1: return-from-trap redirect.
REQ-015 SHALL have port Epc, input, XLEN: Mret target.
REQ-016 SHALL have port PC, output, XLEN, registered: current fetch address.
REQ-017 SHALL have port PC_Plus_Step, output, XLEN, combinational: PC + STEP.
REQ-018 SHALL have port RAS_Count, output, $clog2(RAS_DEPTH+1), registered: valid entries.
REQ-019 SHALL have port Ret_Underflow, output, 1, registered: one-cycle pulse on Ret with empty RAS.

Function
REQ-020 SHALL update PC once per rising CLK with priority Reset > Trap > Mret > Busy > Ret > PCSrc > sequential.
REQ-021 SHALL load Trap_Vector on Trap regardless of Busy; RAS unchanged.
REQ-022 SHALL load Epc on Mret (Trap low) regardless of Busy; RAS unchanged.
REQ-023 SHALL hold PC, RAS contents, RAS_Count when Busy high and no Trap/Mret; Ret_Underflow 0 that cycle.
REQ-024 SHALL, "accepted" = not Reset, Trap, Mret, Busy; Call/Ret/PCSrc take effect only when accepted.
REQ-025 SHALL, on accepted Ret with RAS_Count>0, load PC with top entry and decrement RAS_Count; PCSrc/Result ignored.
REQ-026 SHALL, on accepted Ret with RAS_Count=0, load PC with Result, keep count 0, assert Ret_Underflow next cycle only.
REQ-027 SHALL, on accepted PCSrc without Ret, load PC with Result; else load PC_Plus_Step (mod 2^XLEN, wraps).
REQ-028 SHALL, on accepted Call, push PC_Plus_Step; Call is independent of PCSrc for push purposes.
REQ-029 SHALL, on push with RAS_Count=RAS_DEPTH, overwrite oldest entry (circular), count stays RAS_DEPTH.
REQ-030 SHALL, on accepted Call and Ret together, pop then push: top replaced by PC_Plus_Step, count unchanged, PC = old top (or Result and Underflow if empty, then count becomes 1).
REQ-031 SHALL compute PC_Plus_Step from registered PC only; no combinational path from inputs to PC.

Reset
REQ-032 SHALL, on Reset high at rising CLK, set PC=RESET_VECTOR, RAS_Count=0, Ret_Underflow=0, overriding all inputs.
REQ-033 SHALL not require RAS entry storage to be reset; entries beyond RAS_Count are never output.
REQ-034 SHALL, on Reset asserted mid-stall or mid-trap, complete reset in that cycle; first fetch after release is RESET_VECTOR.

Verification
REQ-035 SHALL test: Reset 1 cycle, then 3 idle cycles -> PC 0x0,0x4,0x8,0xC.
REQ-036 SHALL test: PC=0x100, Call+PCSrc Result=0x400; later Ret -> PC 0x400 then 0x104, RAS_Count 1->0.
REQ-037 SHALL test: 5 Calls from 0x0,0x10,0x20,0x30,0x40 (DEPTH 4), 4 Rets -> returns 0x44,0x34,0x24,0x14; count saturates at 4.
REQ-038 SHALL test: Ret with empty RAS, Result=0x80 -> PC 0x80, Ret_Underflow high exactly one cycle.
REQ-039 SHALL test: Busy high with PCSrc=1 for 3 cycles -> PC held; Trap with Trap_Vector=0x200 during Busy -> PC 0x200 next cycle.
REQ-040 SHALL test: PC=32'hFFFF_FFFC, idle -> PC wraps to 0x0; Reset during Busy -> PC=RESET_VECTOR, count 0.
